// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_if
//  Purpose  : Bundles the control unit's datapath-facing signals.
//             The master modport belongs to the control unit. It samples the
//             opcode and zero flag and drives every enable, mux select and
//             debug output. The slave modport is the datapath's view.
//  Signals  : opcode_i, zero_i                        (datapath -> control)
//             pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
//             reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
//             alu_src_b_o[1:0], pc_src_o[1:0], alu_op_o[ALU_OP_W-1:0],
//             illegal_o, state_o[STATE_W-1:0]          (control -> datapath)
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 3,
  parameter int STATE_W  = 4
);
  logic [OPCODE_W-1:0] opcode_i;
  logic                zero_i;
  logic                pc_write_o;
  logic                i_or_d_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                ir_write_o;
  logic                reg_dst_o;
  logic                mem_to_reg_o;
  logic                reg_write_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [1:0]          pc_src_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic                illegal_o;
  logic [STATE_W-1:0]  state_o;

  modport master (
    input  opcode_i, zero_i,
    output pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           pc_src_o, alu_op_o, illegal_o, state_o
  );

  modport slave (
    output opcode_i, zero_i,
    input  pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           pc_src_o, alu_op_o, illegal_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Main control FSM for the multicycle MIPS datapath. It
//             sequences fetch, decode, execute, memory and writeback. It
//             drives all datapath enables and muxes, plus alu_op for the
//             downstream ALU control decoder.
//  Ports    : clk    - system clock, rising edge
//             reset  - asynchronous, active-low reset
//             ctrl   - multicycle_control_unit_if.master
//                      (opcode/zero in; enables, selects, alu_op,
//                       illegal pulse and debug state out)
//  Config   : MULTICYCLE_JUMP_EN - when defined, opcode 000010 runs through
//             the JUMP state. Otherwise it is treated as an illegal opcode,
//             and state encoding 15 is unused.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 3,
  parameter int STATE_W  = 4
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  multicycle_control_unit_if.master    ctrl
);

`ifdef MULTICYCLE_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // Opcodes decoded by the FSM
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'b001111);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

  // ALU operation codes for the ALU control decoder
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(3'b011);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(3'b100);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3'b101);
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(3'b110);
  localparam logic [ALU_OP_W-1:0] ALU_FUNC = ALU_OP_W'(3'b111);

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = STATE_W'(0),
    S_FETCH     = STATE_W'(1),
    S_DECODE    = STATE_W'(2),
    S_MEM_ADDR  = STATE_W'(3),
    S_MEM_RD    = STATE_W'(4),
    S_LW_WB     = STATE_W'(5),
    S_MEM_WR    = STATE_W'(6),
    S_EXEC_R    = STATE_W'(7),
    S_R_WB      = STATE_W'(8),
    S_EXEC_ADDI = STATE_W'(9),
    S_EXEC_ORI  = STATE_W'(10),
    S_EXEC_LUI  = STATE_W'(11),
    S_I_WB      = STATE_W'(12),
    S_BEQ       = STATE_W'(13),
    S_BNE       = STATE_W'(14),
    S_JUMP      = STATE_W'(15)
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                w_pc_write;
  logic                w_i_or_d;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_ir_write;
  logic                w_reg_dst;
  logic                w_mem_to_reg;
  logic                w_reg_write;
  logic                w_alu_src_a;
  logic [1:0]          w_alu_src_b;
  logic [1:0]          w_pc_src;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_illegal;

  // The asynchronous reset forces RESET, and every output decodes to 0 in
  // RESET. So a store or writeback in progress is cut off in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    w_pc_write   = 1'b0;
    w_i_or_d     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_src     = 2'b00;
    w_alu_op     = '0;
    w_illegal    = 1'b0;

    case (r_state)
      S_RESET: begin
        w_next_state = S_FETCH;
      end

      // Read the instruction and increment the PC in parallel (PC + 4)
      S_FETCH: begin
        w_mem_read   = 1'b1;
        w_ir_write   = 1'b1;
        w_alu_src_b  = 2'b01;
        w_alu_op     = ALU_ADD;
        w_pc_write   = 1'b1;
        w_pc_src     = 2'b00;
        w_next_state = S_DECODE;
      end

      // Speculatively compute the branch target (PC + imm<<2) into ALUOut
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_op    = ALU_ADD;
        case (ctrl.opcode_i)
          OP_RTYPE:      w_next_state = S_EXEC_R;
          OP_ADDI:       w_next_state = S_EXEC_ADDI;
          OP_ORI:        w_next_state = S_EXEC_ORI;
          OP_LUI:        w_next_state = S_EXEC_LUI;
          OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
          OP_BEQ:        w_next_state = S_BEQ;
          OP_BNE:        w_next_state = S_BNE;
          default: begin
            if (JUMP_EN && (ctrl.opcode_i == OP_J)) begin
              w_next_state = S_JUMP;
            end else begin
              w_next_state = S_FETCH;
              w_illegal    = 1'b1;
            end
          end
        endcase
      end

      S_MEM_ADDR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_alu_op     = ALU_ADD;
        // Only LW and SW reach this state, so anything other than LW is SW
        w_next_state = (ctrl.opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        w_mem_read   = 1'b1;
        w_i_or_d     = 1'b1;
        w_next_state = S_LW_WB;
      end

      S_LW_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEM_WR: begin
        w_mem_write  = 1'b1;
        w_i_or_d     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_EXEC_R: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b00;
        w_alu_op     = ALU_FUNC;
        w_next_state = S_R_WB;
      end

      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_next_state = S_FETCH;
      end

      S_EXEC_ADDI, S_EXEC_ORI, S_EXEC_LUI: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_alu_op     = (r_state == S_EXEC_ADDI) ? ALU_ADD :
                       (r_state == S_EXEC_ORI)  ? ALU_OR  : ALU_LUI;
        w_next_state = S_I_WB;
      end

      S_I_WB: begin
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      // Compare rs and rt by subtracting them. The PC loads ALUOut (the
      // target computed in DECODE) only when the zero-flag condition holds.
      S_BEQ, S_BNE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b00;
        w_alu_op     = ALU_SUB;
        w_pc_src     = 2'b01;
        w_pc_write   = (r_state == S_BEQ) ? ctrl.zero_i : ~ctrl.zero_i;
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        // Without jump support this encoding is unused. It idles with
        // outputs low and recovers to FETCH.
        if (JUMP_EN) begin
          w_pc_write = 1'b1;
          w_pc_src   = 2'b10;
        end
        w_next_state = S_FETCH;
      end

      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  assign ctrl.pc_write_o   = w_pc_write;
  assign ctrl.i_or_d_o     = w_i_or_d;
  assign ctrl.mem_read_o   = w_mem_read;
  assign ctrl.mem_write_o  = w_mem_write;
  assign ctrl.ir_write_o   = w_ir_write;
  assign ctrl.reg_dst_o    = w_reg_dst;
  assign ctrl.mem_to_reg_o = w_mem_to_reg;
  assign ctrl.reg_write_o  = w_reg_write;
  assign ctrl.alu_src_a_o  = w_alu_src_a;
  assign ctrl.alu_src_b_o  = w_alu_src_b;
  assign ctrl.pc_src_o     = w_pc_src;
  assign ctrl.alu_op_o     = w_alu_op;
  assign ctrl.illegal_o    = w_illegal;
  assign ctrl.state_o      = r_state;

endmodule
`default_nettype wire
